// File: rtl/pdm_stereo_deserializer.sv
// Stereo PDM deserializer: generates the microphone clock, takes the left bit before each
// falling edge and the right bit before each rising edge, and emits raw or density words.
module pdm_stereo_deserializer #(
  parameter int unsigned WORD_LENGTH        = 16,
  parameter int unsigned SYSTEM_FREQUENCY   = 100000000,
  parameter int unsigned SAMPLING_FREQUENCY = 1000000
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   enable_i,
  input  logic                   mode_i,
  output logic                   pdm_clk_o,
  input  logic                   pdm_data_i,
  output logic [WORD_LENGTH-1:0] data_left_o,
  output logic [WORD_LENGTH-1:0] data_right_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overrun_o
);

  localparam int unsigned HALF = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY / 2;
  localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned IW   = $clog2(WORD_LENGTH);
  localparam int unsigned NW   = $clog2(WORD_LENGTH + 1);

  if (HALF < 1) begin : g_half_check
    $error("pdm_stereo_deserializer: HALF must be >= 1");
  end
  if (WORD_LENGTH < 2) begin : g_word_check
    $error("pdm_stereo_deserializer: WORD_LENGTH must be >= 2");
  end

  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pdm_clk_q, pdm_clk_d;
  logic                   started_q, started_d;
  logic [IW-1:0]          bit_idx_q, bit_idx_d;
  logic [WORD_LENGTH-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic [NW-1:0]          ones_l_q, ones_l_d, ones_r_q, ones_r_d;
  logic                   mode_q, mode_d;
  logic [WORD_LENGTH-1:0] data_l_q, data_l_d, data_r_q, data_r_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic tick, left_smp, right_smp, last;

  assign tick      = (cnt_q == CW'(HALF - 1));
  assign left_smp  = tick & pdm_clk_q;
  // The very first rising edge after enable has no preceding left bit, so it is skipped.
  assign right_smp = tick & ~pdm_clk_q & started_q;
  assign last      = right_smp & (bit_idx_q == IW'(WORD_LENGTH - 1));

  always_comb begin
    cnt_d     = cnt_q;
    pdm_clk_d = pdm_clk_q;
    started_d = started_q;
    bit_idx_d = bit_idx_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    ones_l_d  = ones_l_q;
    ones_r_d  = ones_r_q;
    mode_d    = mode_q;
    data_l_d  = data_l_q;
    data_r_d  = data_r_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (!enable_i) begin
      cnt_d     = '0;
      pdm_clk_d = 1'b0;
      started_d = 1'b0;
      bit_idx_d = '0;
      shift_l_d = '0;
      shift_r_d = '0;
      ones_l_d  = '0;
      ones_r_d  = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (tick) begin
        cnt_d     = '0;
        pdm_clk_d = ~pdm_clk_q;
        started_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      if (left_smp) begin
        shift_l_d = {shift_l_q[WORD_LENGTH-2:0], pdm_data_i};
        ones_l_d  = ones_l_q + NW'(pdm_data_i);
        if (bit_idx_q == '0) mode_d = mode_i;
      end

      if (right_smp) begin
        shift_r_d = {shift_r_q[WORD_LENGTH-2:0], pdm_data_i};
        ones_r_d  = ones_r_q + NW'(pdm_data_i);
        bit_idx_d = last ? '0 : bit_idx_q + IW'(1);
      end

      if (last) begin
        ones_l_d = '0;
        ones_r_d = '0;
        if (!valid_q || ready_i) begin
          data_l_d = mode_q ? WORD_LENGTH'(ones_l_q) : shift_l_q;
          data_r_d = mode_q ? WORD_LENGTH'(ones_r_q + NW'(pdm_data_i))
                            : {shift_r_q[WORD_LENGTH-2:0], pdm_data_i};
          valid_d  = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      cnt_q     <= '0;
      pdm_clk_q <= 1'b0;
      started_q <= 1'b0;
      bit_idx_q <= '0;
      shift_l_q <= '0;
      shift_r_q <= '0;
      ones_l_q  <= '0;
      ones_r_q  <= '0;
      mode_q    <= 1'b0;
      data_l_q  <= '0;
      data_r_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pdm_clk_q <= pdm_clk_d;
      started_q <= started_d;
      bit_idx_q <= bit_idx_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      ones_l_q  <= ones_l_d;
      ones_r_q  <= ones_r_d;
      mode_q    <= mode_d;
      data_l_q  <= data_l_d;
      data_r_q  <= data_r_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign pdm_clk_o    = pdm_clk_q;
  assign data_left_o  = data_l_q;
  assign data_right_o = data_r_q;
  assign valid_o      = valid_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_pdm_stereo_deserializer.sv
// Scoreboard bench for pdm_stereo_deserializer: a timeline model predicts sample instants,
// frame words and handshake state; a monitor compares every accepted word and status bit.
module tb_pdm_stereo_deserializer;

  localparam int W    = 8;
  localparam int HALF = 4;

  logic         clk = 1'b0;
  logic         rst_n, en, mode, ready, pdm_data;
  logic         pdm_clk, valid, ovr;
  logic [W-1:0] dl, dr;

  always #5 clk = ~clk;

  pdm_stereo_deserializer #(
    .WORD_LENGTH       (W),
    .SYSTEM_FREQUENCY  (8),
    .SAMPLING_FREQUENCY(1)
  ) dut (
    .clock_i     (clk),
    .reset_ni    (rst_n),
    .enable_i    (en),
    .mode_i      (mode),
    .pdm_clk_o   (pdm_clk),
    .pdm_data_i  (pdm_data),
    .data_left_o (dl),
    .data_right_o(dr),
    .valid_o     (valid),
    .ready_i     (ready),
    .overrun_o   (ovr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge t (counted from the first enabled edge): 0 none, 1 left sample, 2 right sample.
  function automatic int phase(input int tt);
    int p;
    if (tt % HALF != HALF - 1) return 0;
    p = tt / HALF;
    if (p % 2 == 1) return 1;
    if (p > 0) return 2;
    return 0;
  endfunction

  function automatic int bit_of(input int tt);
    return (((tt / HALF) - 1) / 2) % W;
  endfunction

  typedef struct {int l; int r;} pair_t;
  pair_t q[$];

  int t           = 0;
  int frames_done = 0;
  bit m_valid     = 1'b0;
  bit m_ovr       = 1'b0;
  bit m_clk       = 1'b0;
  bit m_mode      = 1'b0;
  bit lb[W];
  bit rb[W];

  always @(posedge clk) begin
    int    ph, k;
    bit    comp;
    pair_t e;
    if (!rst_n) begin
      t = 0; m_valid = 0; m_ovr = 0; m_clk = 0; m_mode = 0;
      q.delete();
    end else if (!en) begin
      t = 0; m_valid = 0; m_ovr = 0; m_clk = 0;
      q.delete();
    end else begin
      ph   = phase(t);
      k    = bit_of(t);
      comp = 0;
      if (ph == 1) begin
        if (k == 0) m_mode = mode;
        lb[k] = pdm_data;
      end else if (ph == 2) begin
        rb[k] = pdm_data;
        comp  = (k == W - 1);
      end
      if (comp) begin
        e.l = 0;
        e.r = 0;
        for (int i = 0; i < W; i++) begin
          if (m_mode) begin
            e.l += int'(lb[i]);
            e.r += int'(rb[i]);
          end else begin
            e.l += int'(lb[i]) << (W - 1 - i);
            e.r += int'(rb[i]) << (W - 1 - i);
          end
        end
        frames_done++;
        if (!m_valid || ready) begin
          q.push_back(e);
          m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
      t++;
      m_clk = ((t / HALF) % 2) == 1;
    end
  end

  // Data line driver: directed bits land exactly on sample edges; everything else is noise.
  bit           use_dir = 1'b1;
  logic [W-1:0] dir_l = '0;
  logic [W-1:0] dir_r = '0;

  always @(negedge clk) begin
    if (use_dir && phase(t) == 1)      pdm_data = dir_l[W-1-bit_of(t)];
    else if (use_dir && phase(t) == 2) pdm_data = dir_r[W-1-bit_of(t)];
    else                               pdm_data = 1'($urandom % 2);
  end

  always begin
    pair_t e;
    @(negedge clk);
    #1;
    check("valid_o", 32'(valid), 32'(m_valid));
    check("overrun_o", 32'(ovr), 32'(m_ovr));
    check("pdm_clk_o", 32'(pdm_clk), 32'(m_clk));
    if (valid === 1'b1 && ready === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: got a word handshake, expected none queued (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        check("sb_left", 32'(dl), 32'(e.l));
        check("sb_right", 32'(dr), 32'(e.r));
      end
    end
  end

  task automatic wait_frame();
    int start;
    start = frames_done;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frames_done != start) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_frame: got no completion in 200 cycles, expected one");
  endtask

  initial begin
    int thr;
    rst_n = 0; en = 1; mode = 0; ready = 1;

    // Reset held with enable high
    repeat (2) begin
      @(negedge clk);
      check("rst_pdm_clk", 32'(pdm_clk), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_ovr", 32'(ovr), 0);
      check("rst_left", 32'(dl), 0);
      check("rst_right", 32'(dr), 0);
    end

    // Raw capture
    dir_l = 8'hA5; dir_r = 8'h3C;
    rst_n = 1;
    wait_frame();
    check("raw_valid", 32'(valid), 1);
    check("raw_left", 32'(dl), 32'h A5);
    check("raw_right", 32'(dr), 32'h3C);

    // Density capture
    mode = 1; dir_l = 8'hFF; dir_r = 8'h0F;
    wait_frame();
    check("dens_left", 32'(dl), 32'h08);
    check("dens_right", 32'(dr), 32'h04);
    @(negedge clk);

    // Back-pressure for two frames
    mode = 0; ready = 0; dir_l = 8'h11; dir_r = 8'h22;
    wait_frame();
    check("bp1_valid", 32'(valid), 1);
    check("bp1_left", 32'(dl), 32'h11);
    check("bp1_ovr", 32'(ovr), 0);
    dir_l = 8'h33; dir_r = 8'h44;
    wait_frame();
    check("bp2_left", 32'(dl), 32'h11);
    check("bp2_right", 32'(dr), 32'h22);
    check("bp2_ovr", 32'(ovr), 1);
    ready = 1;
    @(negedge clk);
    check("bp_drain_valid", 32'(valid), 0);
    check("bp_drain_ovr", 32'(ovr), 1);

    // Reset three bits into a frame
    repeat (2 * HALF * 3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("midrst_pdm_clk", 32'(pdm_clk), 0);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_ovr", 32'(ovr), 0);
    dir_l = 8'h5A; dir_r = 8'hC3;
    rst_n = 1;
    wait_frame();
    check("post_rst_left", 32'(dl), 32'h5A);
    check("post_rst_right", 32'(dr), 32'hC3);
    @(negedge clk);

    // Disable three bits into a frame; words must hold
    repeat (2 * HALF * 3) @(negedge clk);
    en = 0;
    @(negedge clk);
    check("dis_pdm_clk", 32'(pdm_clk), 0);
    check("dis_valid", 32'(valid), 0);
    check("dis_left_hold", 32'(dl), 32'h5A);
    check("dis_right_hold", 32'(dr), 32'hC3);
    repeat (3) @(negedge clk);
    dir_l = 8'h96; dir_r = 8'h69;
    en = 1;
    wait_frame();
    check("reen_left", 32'(dl), 32'h96);
    check("reen_right", 32'(dr), 32'h69);
    @(negedge clk);

    // Handshake coincident with completion
    ready = 0; dir_l = 8'h12; dir_r = 8'h34;
    wait_frame();
    check("coin_hold_valid", 32'(valid), 1);
    dir_l = 8'h56; dir_r = 8'h78;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (phase(t) == 2 && bit_of(t) == W - 1) break;
    end
    ready = 1;
    @(negedge clk);
    check("coin_valid", 32'(valid), 1);
    check("coin_left", 32'(dl), 32'h56);
    check("coin_right", 32'(dr), 32'h78);
    check("coin_ovr", 32'(ovr), 0);

    // Random traffic, back-pressure, mode flips, disables and resets
    use_dir = 0;
    thr = 70;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (c % 256 == 0) thr = int'($urandom_range(2, 95));
      ready = (int'($urandom % 100) < thr);
      if ($urandom % 97 == 0) mode = ~mode;
      en    = ($urandom % 1500 != 0);
      rst_n = ($urandom % 3000 != 0);
    end

    rst_n = 1; en = 1; ready = 1;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
